// File: rtl/write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : write_ctrl
// Purpose  : Producer-side controller for a two-slot ping-pong byte buffer.
//            Optional dropped-byte counter enabled by WRITE_CTRL_DROP_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module write_ctrl #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_vld,
    output logic          din_rdy,
    output logic          din_err,
    input  logic [1:0]    status_vld,
    output logic          w_addr,
    output logic [DW-1:0] w_data,
    output logic          w_en,
    output logic [1:0]    w_done
`ifdef WRITE_CTRL_DROP_CNT_EN
    ,
    output logic [7:0]    drop_cnt
`endif
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_WAIT  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t        state_q;
    logic          w_addr_q;
    logic [DW-1:0] w_data_q;
    logic          din_rdy_q;
    logic          w_en_q;
    logic [1:0]    w_done_q;
    logic          din_err_q;

    // Outputs are registered alongside the state, so each one reflects
    // exactly the state being entered and never an input path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_INIT;
            w_addr_q  <= 1'b0;
            w_data_q  <= '0;
            din_rdy_q <= 1'b0;
            w_en_q    <= 1'b0;
            w_done_q  <= 2'b00;
            din_err_q <= 1'b0;
        end else begin
            din_rdy_q <= 1'b0;
            w_en_q    <= 1'b0;
            w_done_q  <= 2'b00;
            din_err_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    state_q   <= S_WAIT;
                    din_rdy_q <= 1'b1;
                end
                S_WAIT: begin
                    if (din_vld) begin
                        if (status_vld[w_addr_q]) begin
                            state_q   <= S_ERR;
                            din_err_q <= 1'b1;
                        end else begin
                            state_q  <= S_WRITE;
                            w_data_q <= din;
                            w_en_q   <= 1'b1;
                        end
                    end else begin
                        din_rdy_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    state_q  <= S_DONE;
                    w_done_q <= w_addr_q ? 2'b10 : 2'b01;
                end
                S_DONE: begin
                    state_q   <= S_WAIT;
                    w_addr_q  <= ~w_addr_q;
                    din_rdy_q <= 1'b1;
                end
                S_ERR: begin
                    // Slot pointer is kept so the same slot is retried.
                    state_q   <= S_WAIT;
                    din_rdy_q <= 1'b1;
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

`ifdef WRITE_CTRL_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 8'h00;
        end else if (state_q == S_WAIT && din_vld && status_vld[w_addr_q]
                     && drop_cnt_q != 8'hFF) begin
            drop_cnt_q <= drop_cnt_q + 8'h01;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign din_rdy = din_rdy_q;
    assign din_err = din_err_q;
    assign w_addr  = w_addr_q;
    assign w_data  = w_data_q;
    assign w_en    = w_en_q;
    assign w_done  = w_done_q;

endmodule
`default_nettype wire

// File: tb/tb_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_ctrl
// Purpose  : Self-checking bench for write_ctrl against a timestamped
//            transaction model of the ping-pong write protocol.
// Revision : 1.0  initial release
// ============================================================================
module tb_write_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_vld;
    logic       din_rdy;
    logic       din_err;
    logic [1:0] status_vld;
    logic       w_addr;
    logic [7:0] w_data;
    logic       w_en;
    logic [1:0] w_done;
`ifdef WRITE_CTRL_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    write_ctrl #(.DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_vld    (din_vld),
        .din_rdy    (din_rdy),
        .din_err    (din_err),
        .status_vld (status_vld),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .w_en       (w_en),
        .w_done     (w_done)
`ifdef WRITE_CTRL_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: each accepted offer schedules its output events at absolute
    // cycle numbers relative to the handshake cycle.
    int         cyc, rdy_at, wen_t, done_t, err_t, toggle_t, m_drops, m_hs;
    logic       m_ptr;
    logic [7:0] m_wdata;
    logic [1:0] m_mask;
    logic [13:0] exp_v, obs_v;

    task automatic reset_model();
        cyc = 0; rdy_at = 1; wen_t = -1; done_t = -1; err_t = -1;
        toggle_t = -1; m_drops = 0; m_ptr = 1'b0; m_wdata = 8'h00; m_mask = 2'b00;
    endtask

    task automatic expect_now();
        exp_v = {cyc >= rdy_at, cyc == wen_t, (cyc == done_t) ? m_mask : 2'b00,
                 cyc == err_t, m_ptr, m_wdata};
        obs_v = {din_rdy, w_en, w_done, din_err, w_addr, w_data};
    endtask

    task automatic step(input logic vld, input logic [7:0] d, input logic [1:0] st);
        din_vld = vld; din = d; status_vld = st;
        if (vld && cyc >= rdy_at) begin
            m_hs++;
            if (st[m_ptr]) begin
                err_t  = cyc + 1;
                rdy_at = cyc + 2;
                if (m_drops < 255) m_drops++;
            end else begin
                wen_t    = cyc + 1;
                done_t   = cyc + 2;
                toggle_t = cyc + 3;
                rdy_at   = cyc + 3;
                m_wdata  = d;
                m_mask   = m_ptr ? 2'b10 : 2'b01;
            end
        end
        @(posedge clk); #1;
        cyc++;
        if (cyc == toggle_t) m_ptr = ~m_ptr;
        expect_now();
    endtask

    task automatic do_reset();
        rst = 1'b1; din_vld = 1'b0; din = 8'h00; status_vld = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        reset_model();
        expect_now();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (obs_v !== exp_v) begin
            miscompares++;
            $display("FAIL reset_first_cycle got=%h exp=%h", obs_v, exp_v);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 2'b00);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_two_writes();
        logic       v [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] d [8] = '{8'hA5, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) begin
            step(v[i], d[i], 2'b00);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL two_writes cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
        end
        vectors++;
        if (w_addr !== 1'b0 || w_data !== 8'h3C) begin
            miscompares++;
            $display("FAIL two_writes_end got addr=%b data=%h exp addr=0 data=3c", w_addr, w_data);
        end
    endtask

    task automatic test_overflow_recovery();
        do_reset();
        step(1'b0, 8'h00, 2'b00);
        for (int i = 0; i < 7; i++) begin
            if (i == 0)      step(1'b1, 8'h77, 2'b01);
            else if (i == 3) step(1'b1, 8'h11, 2'b00);
            else             step(1'b0, 8'h00, (i < 3) ? 2'b01 : 2'b00);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL overflow_recovery cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
        end
`ifdef WRITE_CTRL_DROP_CNT_EN
        vectors++;
        if (drop_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL overflow_drop_cnt got=%0d exp=1", drop_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_write();
        step(1'b1, 8'hC3, 2'b00);
        vectors++;
        if (w_en !== 1'b1) begin
            miscompares++;
            $display("FAIL midwrite_setup got w_en=%b exp=1", w_en);
        end
        rst = 1'b1; din_vld = 1'b0;
        @(posedge clk); #1;
        obs_v = {din_rdy, w_en, w_done, din_err, w_addr, w_data};
        vectors++;
        if (obs_v !== 14'h0) begin
            miscompares++;
            $display("FAIL midwrite_reset got=%h exp=0000", obs_v);
        end
        rst = 1'b0;
        reset_model();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 2'b00);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL midwrite_after cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom_range(0, 3)));
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_saturation();
        int errs = 0;
        int hs0;
        int guard = 0;
        do_reset();
        m_hs = 0;
        hs0 = m_hs;
        while (m_hs - hs0 < 300 && guard < 2000) begin
            step(1'b1, 8'($urandom), 2'b11);
            guard++;
            if (din_err === 1'b1) errs++;
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL saturation cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 2'b11);
            if (din_err === 1'b1) errs++;
        end
        vectors++;
        if (errs != 300 || guard >= 2000) begin
            miscompares++;
            $display("FAIL saturation_err_pulses got=%0d exp=300 (cycles=%0d)", errs, guard);
        end
`ifdef WRITE_CTRL_DROP_CNT_EN
        vectors++;
        if (drop_cnt !== 8'hFF) begin
            miscompares++;
            $display("FAIL saturation_drop_cnt got=%h exp=ff", drop_cnt);
        end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        m_hs = 0;
        test_reset();
        test_two_writes();
        test_overflow_recovery();
        test_reset_mid_write();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
